// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential right shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    // Bits needed to index stages 0..s-1; never narrower than one bit.
    function automatic int stage_width(input int s);
        return (s <= 2) ? 1 : $clog2(s);
    endfunction

endpackage

// File: rtl/shift_right_stage.sv
// One binary-weighted right-shift stage: shifts by 2^stage when enabled,
// filling the vacated top bits with the fill bit.
module shift_right_stage
    import shift_pkg::*;
#(
    parameter int N  = 32,
    parameter int S  = $clog2(N),
    parameter int CW = stage_width(S)
) (
    input  logic [N-1:0]  data,
    input  logic [CW-1:0] stage,
    input  logic          enable,
    input  logic          fill,
    output logic [N-1:0]  result
);

    logic [N-1:0] shifted [S];

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_stage
            localparam int W = 1 << gi;
            assign shifted[gi] = {{W{fill}}, data[N-1:W]};
        end
    endgenerate

    always_comb begin
        result = data;
        if (enable) begin
            for (int i = 0; i < S; i++) begin
                if (stage == CW'(i)) begin
                    result = shifted[i];
                end
            end
        end
    end

endmodule

// File: rtl/shift_right_sequential.sv
// Multi-cycle logical/arithmetic right shifter: one binary-weighted stage per
// clock, fixed latency of S cycles, valid/ready on both sides.
module shift_right_sequential
    import shift_pkg::*;
#(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] i_data,
    input  logic [S-1:0] i_shamt,
    input  logic         i_arith,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] o_data,
    output logic         busy
);

    localparam int CW = stage_width(S);
    localparam logic [CW-1:0] LAST_STAGE = CW'(S - 1);

    shift_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic [S-1:0]  shamt_q, shamt_d;
    logic          arith_q, arith_d;

    logic [N-1:0]  stage_out;
    logic          stage_en;
    logic          fill_bit;

    // The MSB survives every right shift, so the current top bit is the
    // sign of the captured operand throughout the operation.
    assign fill_bit = arith_q & data_q[N-1];
    assign stage_en = shamt_q[cnt_q];

    shift_right_stage #(
        .N  (N),
        .S  (S),
        .CW (CW)
    ) u_stage (
        .data   (data_q),
        .stage  (cnt_q),
        .enable (stage_en),
        .fill   (fill_bit),
        .result (stage_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        arith_d = arith_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    shamt_d = i_shamt;
                    arith_d = i_arith;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d = stage_out;
                if (cnt_q == LAST_STAGE) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (o_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs depend on state alone; unknown encodings look idle.
    always_comb begin
        i_ready = 1'b0;
        o_valid = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy    = 1'b1;
                o_valid = 1'b1;
            end
            default: i_ready = 1'b1;
        endcase
    end

    assign o_data = data_q;

endmodule

// File: tb/tb_shift_right_sequential.sv
// Randomised and directed bench for shift_right_sequential against a
// behavioural >> / >>> reference.
module tb_shift_right_sequential;

    localparam int N = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready;
    logic [N-1:0] i_data = '0;
    logic [S-1:0] i_shamt = '0;
    logic         i_arith = 1'b0;
    logic         o_valid;
    logic         o_ready = 1'b0;
    logic [N-1:0] o_data;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_right_sequential #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_shamt (i_shamt),
        .i_arith (i_arith),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic [S-1:0] sh, input logic a);
        logic signed [N-1:0] sd;
        sd = d;
        if (a) return N'(sd >>> sh);
        return d >> sh;
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_op(input string tag, input logic [N-1:0] d, input logic [S-1:0] sh,
                          input logic a, input int stall, input bit noisy);
        logic [N-1:0] exp;
        logic [N-1:0] held;
        int lat;
        exp = model(d, sh, a);
        check({tag, "_ready_idle"}, 64'(i_ready), 64'd1);
        i_data  = d;
        i_shamt = sh;
        i_arith = a;
        i_valid = 1'b1;
        o_ready = (stall == 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            check({tag, "_busy_ready"}, {busy, i_ready}, 64'b10);
            if (noisy) begin
                i_valid = 1'($urandom);
                i_data  = $urandom;
                i_shamt = S'($urandom);
                i_arith = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(S));
        check({tag, "_data"}, 64'(o_data), 64'(exp));
        held = o_data;
        for (int k = 0; k < stall; k++) begin
            i_valid = 1'($urandom);
            i_data  = $urandom;
            @(posedge clk); #1;
            check({tag, "_stall_hold"}, {o_valid, i_ready, busy, o_data}, {3'b101, held});
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_release"}, {o_valid, i_ready, busy}, 64'b010);
    endtask

    initial begin
        #2;
        check("reset_outputs", {o_valid, busy, i_ready, o_data}, {3'b001, 32'h0});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset", {o_valid, busy, i_ready}, 64'b001);

        run_op("logical4",   32'hF000_0000, 5'd4,  1'b0, 0, 1'b0);
        run_op("arith31",    32'h8000_0000, 5'd31, 1'b1, 0, 1'b0);
        run_op("logical31",  32'h8000_0000, 5'd31, 1'b0, 0, 1'b0);
        run_op("zero_shift", 32'h1234_5678, 5'd0,  1'b1, 0, 1'b0);
        run_op("pos_arith3", 32'h7FFF_FFFF, 5'd3,  1'b1, 0, 1'b0);
        run_op("backpress",  32'hDEAD_BEEF, 5'd7,  1'b1, 4, 1'b1);
        check("logical4_const", 64'(model(32'hF000_0000, 5'd4, 1'b0)), 64'h0F00_0000);

        // Abort in the third SHIFT cycle; outputs must drop without a clock.
        i_data = 32'hA5A5_A5A5; i_shamt = 5'd9; i_arith = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midop_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("midop_abort", {o_valid, busy, i_ready}, 64'b001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset", 32'hFFFF_0000, 5'd16, 1'b0, 0, 1'b0);

        for (int t = 0; t < 1000; t++) begin
            run_op("rand", $urandom, S'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_right_sequential.md
Name: shift_right_sequential

Overview:
- Multi-cycle right shifter, logical or arithmetic; the right-direction counterpart to the combinational left-logical shifter in the ALU datapath.
- Performs one binary-weighted shift stage per clock: stage k shifts by 2^k when shamt[k]=1.
- Latency is fixed at $clog2(N) stage cycles.
- Valid/ready handshakes on input and output let it sit behind the register file and feed writeback, or a multi-cycle ALU path, without a combinational 32:1 mux.

Parameters:
- N, 32, data width; power of two, >= 4.
- S, $clog2(N), shamt width and stage count (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset: asserting low resets immediately; deassertion is synchronous to clk.
- i_valid  input  1  request valid.
- i_ready  output  1  block can accept a request.
- i_data  input  N  operand to shift.
- i_shamt  input  S  shift amount, 0..N-1.
- i_arith  input  1  1 = arithmetic (fill with i_data[N-1]), 0 = logical (fill with 0).
- o_valid  output  1  result valid.
- o_ready  input  1  downstream accepts result.
- o_data  output  N  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States: IDLE, SHIFT, DONE. The state enum is 2 bits.
- Reset (rst low, async): state=IDLE, stage counter=0, data/shamt/arith registers=0, o_valid=0, o_data=0, busy=0, i_ready=1 once reset is released.
- IDLE:
  - i_ready=1, o_valid=0.
  - On a clk edge with i_valid&i_ready: capture i_data, i_shamt, i_arith; counter=0; go to SHIFT.
- SHIFT:
  - i_ready=0.
  - Each edge: if shamt[counter]=1, data <= data >> 2^counter, with the top 2^counter bits filled by the fill bit; otherwise data is held. Then counter++.
  - Fill bit = arith & data[N-1] of the originally captured operand. Right shifts preserve the MSB, so the current data[N-1] gives the same value.
  - On the edge where counter==S-1: perform the final stage, go to DONE.
  - Exactly S cycles spent in SHIFT, independent of shamt. shamt=0 still takes S cycles.
- DONE:
  - o_valid=1; o_data = final data register, held stable while o_valid&!o_ready.
  - On an edge with o_ready=1: go to IDLE, o_valid=0.
  - i_ready=0 in DONE. No new request is accepted until the cycle after the output handshake.
- Latency: request accepted at edge E0; o_valid rises after edge E0+S (S=5 → 5 cycles). Throughput is one result per S+2 cycles with o_ready tied high.
- o_data is registered. No combinational path from inputs to outputs. i_ready and o_valid are decoded from state only.
- Inputs are ignored outside IDLE. i_data/i_shamt changes during SHIFT/DONE do not affect the result.
- Reset mid-operation (SHIFT or DONE): abort immediately, o_valid drops asynchronously, and the result is lost.
- Width rules:
  - Arithmetic shift of a negative value by N-1 yields all ones.
  - Logical shift by N-1 yields {(N-1){0}, data[N-1]}.
- X-safety: the counter never exceeds S-1; any out-of-range state decodes to IDLE.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t.
  - localparam stage width helper.
- Sub-module shift_right_stage:
  - Combinational, parameterized by N.
  - Inputs: data, stage index, enable, fill bit. Output: data shifted right by 2^stage when enabled.
  - Instantiated once and driven by the counter.
- Top module holds the FSM, counter, and registers.

Test Plan:
- Logical: i_data=32'hF000_0000, shamt=4, arith=0 → o_data=32'h0F00_0000, o_valid exactly 5 cycles after accept.
- Arithmetic: i_data=32'h8000_0000, shamt=31, arith=1 → 32'hFFFF_FFFF; same operand with arith=0 → 32'h0000_0001.
- Zero shift / positive arithmetic: i_data=32'h1234_5678, shamt=0 → 32'h1234_5678 after 5 cycles; i_data=32'h7FFF_FFFF, shamt=3, arith=1 → 32'h0FFF_FFFF.
- Backpressure: hold o_ready=0 for 4 cycles in DONE → o_valid and o_data stable, i_ready=0, i_valid pulses ignored; release → IDLE next cycle, i_ready=1.
- Reset mid-op: assert rst low during the 3rd SHIFT cycle → o_valid=0, busy=0 immediately; after release a new request for 32'hFFFF_0000, shamt=16, logical → 32'h0000_FFFF.
- Random: 1000 random (data, shamt, arith) with random o_ready stalls → matches a reference model using >> and >>>; no accept while busy.
